// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq
//   Sequential three-digit BCD to 8-bit binary converter. It uses reverse
//   double-dabble: on each cycle the {bcd,work} register is shifted right by
//   one, and every BCD nibble that ends up >= 8 is reduced by 3. The block
//   converts the switch value (HUNDREDS/TENS/ONES) into the binary value that
//   the counter/adder datapath uses.
//
// Ports
//   CLOCK_50  in   system clock, rising edge
//   RESET_N   in   asynchronous active-low reset
//   start     in   conversion request, sampled only in IDLE
//   HUNDREDS  in   [1:0] hundreds digit (0..2 legal)
//   TENS      in   [3:0] tens digit (0..9 legal)
//   ONES      in   [3:0] ones digit (0..9 legal)
//   BIN       out  [7:0] registered result, held between conversions
//   busy      out  high while shifting
//   done      out  one-cycle pulse, BIN/err valid while high
//   err       out  registered, 1 if the last request was invalid
//
// state  | meaning
// S_IDLE | waiting for start; inputs captured and checked on the start edge
// S_SHIFT| one shift+correct per cycle, N_SHIFT cycles; an invalid request
//        | spends exactly one cycle here (busy low) before reporting
// S_DONE | single-cycle result state, done high
module bcd_to_binary_seq #(
  parameter int N_SHIFT = 8
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  input  logic               start,
  input  logic [1:0]         HUNDREDS,
  input  logic [3:0]         TENS,
  input  logic [3:0]         ONES,
  output logic [N_SHIFT-1:0] BIN,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CNT_W = (N_SHIFT > 1) ? $clog2(N_SHIFT) : 1;
  localparam int SR_W  = 10 + N_SHIFT;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SHIFT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state;
  logic [SR_W-1:0]  sr;        // {hundreds[1:0], tens[3:0], ones[3:0], work}
  logic [CNT_W-1:0] cnt;
  logic             err_pend;

  logic [SR_W-1:0]  sr_next;
  logic [9:0]       dec_val;
  logic             in_invalid;

  // Shift right, then correct tens and ones nibbles. The hundreds field only
  // ever feeds bits into the tens nibble and is never corrected itself.
  always_comb begin
    sr_next = {1'b0, sr[SR_W-1:1]};
    if (sr_next[N_SHIFT+7:N_SHIFT+4] >= 4'd8)
      sr_next[N_SHIFT+7:N_SHIFT+4] = sr_next[N_SHIFT+7:N_SHIFT+4] - 4'd3;
    if (sr_next[N_SHIFT+3:N_SHIFT] >= 4'd8)
      sr_next[N_SHIFT+3:N_SHIFT] = sr_next[N_SHIFT+3:N_SHIFT] - 4'd3;
  end

  // Max decimal with out-of-range digits is 3*100+15*10+15 = 465, fits 10 bits.
  always_comb begin
    dec_val    = 10'(HUNDREDS) * 10'd100 + 10'(TENS) * 10'd10 + 10'(ONES);
    in_invalid = (TENS > 4'd9) || (ONES > 4'd9) || (HUNDREDS == 2'd3) ||
                 (dec_val > 10'd255);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= S_IDLE;
      sr       <= '0;
      cnt      <= '0;
      err_pend <= 1'b0;
      BIN      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            sr       <= {HUNDREDS, TENS, ONES, {N_SHIFT{1'b0}}};
            cnt      <= '0;
            state    <= S_SHIFT;
            err_pend <= in_invalid;
            busy     <= !in_invalid;
          end
        end

        S_SHIFT: begin
          if (err_pend) begin
            // Invalid request: report on the next edge without shifting.
            err_pend <= 1'b0;
            state    <= S_DONE;
            done     <= 1'b1;
            err      <= 1'b1;
            BIN      <= '0;
          end else begin
            sr  <= sr_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              err   <= 1'b0;
              BIN   <= sr_next[N_SHIFT-1:0];
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
